shift_register_sequencer: RTL and testbench
===========================================

# shift_register_sequencer

Command-level controller that sits directly upstream of the 4-bit parallel-load shift register and drives its S, D and OE inputs. It accepts a word plus a shift command over a valid/ready handshake and issues one load cycle followed by the requested number of shift cycles. It then enables the register output, captures Q and presents the result over a second valid/ready handshake. Downstream logic never has to sequence the register's mode pins by hand.

## Interface
- WIDTH, 4: data width of the controlled shift register.
- CNT_W, 3: width of the shift-count field; must hold 0..WIDTH.

- CLK  in  1  rising-edge clock, shared with the shift register.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  command present.
- IN_READY  out  1  controller can accept a command.
- IN_DATA  in  WIDTH  word to load.
- IN_DIR  in  1  0 = shift right (S=01), 1 = shift left (S=10).
- IN_CNT  in  CNT_W  number of shift cycles; values above WIDTH clamp to WIDTH.
- S  out  2  register mode: 00 hold, 01 right, 10 left, 11 load.
- D  out  WIDTH  register parallel input.
- OE  out  1  register output enable.
- Q  in  WIDTH  register output.
- OUT_VALID  out  1  captured word available.
- OUT_READY  in  1  consumer accepts captured word.
- OUT_DATA  out  WIDTH  captured word.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, SHIFT, ENABLE, CAPTURE, OUT.
- Reset values: S=00, D=0, OE=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, state=IDLE.
- IN_READY = (state==IDLE) && !RST.
- IDLE: S=00 and OE=0. On IN_VALID && IN_READY, latch IN_DATA, IN_DIR and the clamped IN_CNT, then go to LOAD.
- LOAD, one cycle: S=11, D=latched word.
  - Go to SHIFT if the count is nonzero, else go to ENABLE.
- SHIFT: S=01 or 10 per the latched direction. The remaining count decrements each cycle. Exit to ENABLE after exactly CNT cycles.
- ENABLE, one cycle: S=00, OE=1. Gives the register output one cycle to settle.
- CAPTURE, one cycle: S=00, OE=1. Q is registered into OUT_DATA at the closing edge.
- OUT: OE=0, S=00, OUT_VALID=1.
  - OUT_DATA stays stable until OUT_VALID && OUT_READY.
  - After the handshake, go to IDLE.
- D holds the latched word from LOAD until the controller returns to IDLE, then returns to 0.
- S, D, OE and OUT_VALID are registered; no combinational path runs from Q to any output.
- Clamp rule: IN_CNT > WIDTH behaves exactly like IN_CNT = WIDTH.

## Timing
- Accept edge = edge 0. Cycle numbering:
  - LOAD is cycle 1.
  - SHIFT is cycles 2..CNT+1.
  - ENABLE is cycle CNT+2.
  - CAPTURE is cycle CNT+3.
  - OUT_VALID rises in cycle CNT+4.
- Latency from accept to OUT_VALID is CNT+4 cycles.
- Minimum command spacing is CNT+5 cycles, with OUT_READY tied high.
- OUT_READY held low: remain in OUT indefinitely with all outputs stable.
- OUT_READY high on the first OUT cycle: return to IDLE on the next edge. IN_READY is high in the following cycle.
- RST asserted in any state: at the next edge, go to IDLE with all outputs at reset values and in-flight data discarded. The register sees S=00 (hold) from then on.
- RST and IN_VALID in the same cycle: the command is not accepted.

## Structure
- Shared package shift_reg_defs holds:
  - mode constants S_HOLD=2'b00, S_RIGHT=2'b01, S_LEFT=2'b10, S_LOAD=2'b11, also used by the shift register itself;
  - state encodings.
- One sub-module, shift_counter: loadable down-counter with clamp-on-load and a zero flag, used for the SHIFT state.
- The shift register is not instantiated inside this block. The two are connected at the level above.

## Test plan
- Reset check: hold RST for 3 cycles, then release. Expect S=00, OE=0, D=0, OUT_VALID=0 and BUSY=0 during reset; IN_READY=1 in the first cycle after release.
- Right shift: IN_DATA=0101, IN_DIR=0, IN_CNT=1. Expect the S sequence 11, 01, 00, 00 with OE high in the last two cycles. The Q stub drives 0010 in CAPTURE, so OUT_DATA=0010 and OUT_VALID rises 5 cycles after accept.
- Zero count: IN_CNT=0, IN_DATA=1100. Expect LOAD followed directly by ENABLE with no S=01/10 cycle. With Q stub=1100, OUT_VALID rises 4 cycles after accept.
- Clamp and left shift: IN_CNT=7, IN_DIR=1. Expect exactly 4 cycles of S=10, and OUT_VALID 8 cycles after accept.
- Backpressure: hold OUT_READY=0 for 10 cycles in OUT. Expect OUT_DATA stable, IN_READY=0 and OE=0; OUT_READY=1 returns to IDLE on the next edge.
- Mid-operation reset: pulse RST during the second SHIFT cycle of an IN_CNT=3 command. Expect S=00 and BUSY=0 on the next edge, and OUT_VALID never asserted.

Source files
------------

// File: rtl/shift_reg_defs.sv
// Shared definitions for the 4-bit parallel-load shift register and its sequencer.
package shift_reg_defs;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_ENABLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUT     = 3'd5
  } state_e;

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter for the SHIFT phase; load values above WIDTH clamp to WIDTH.
module shift_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_last
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_clamped;

  assign w_clamped = (i_load_val > MAX_CNT) ? MAX_CNT : i_load_val;

  always_ff @(posedge CLK) begin
    if (RST)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= w_clamped;
    else if (i_dec && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
  // Last shift cycle: the counter reaches zero on this edge.
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/shift_register_sequencer.sv
// Command-level controller driving S/D/OE of a parallel-load shift register:
// load, shift N times, enable output, capture Q, hand the result downstream.
module shift_register_sequencer
  import shift_reg_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_DIR,
  input  logic [CNT_W-1:0] IN_CNT,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] D,
  output logic             OE,
  input  logic [WIDTH-1:0] Q,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             BUSY
);

  state_e           r_state, w_next;
  logic             r_dir;
  logic [1:0]       r_s, w_s_next;
  logic [WIDTH-1:0] r_d, w_d_next;
  logic             r_oe, r_out_valid, r_busy;
  logic [WIDTH-1:0] r_out_data;
  logic             w_accept, w_cnt_zero, w_cnt_last;

  assign IN_READY = (r_state == ST_IDLE) && !RST;
  assign w_accept = IN_VALID && IN_READY;

  shift_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_accept),
    .i_load_val(IN_CNT),
    .i_dec     (r_state == ST_SHIFT),
    .o_zero    (w_cnt_zero),
    .o_last    (w_cnt_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_LOAD;
      ST_LOAD:    w_next = w_cnt_zero ? ST_ENABLE : ST_SHIFT;
      ST_SHIFT:   if (w_cnt_last) w_next = ST_ENABLE;
      ST_ENABLE:  w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_OUT;
      ST_OUT:     if (OUT_READY) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they belong to.
  always_comb begin
    w_s_next = S_HOLD;
    case (w_next)
      ST_LOAD:  w_s_next = S_LOAD;
      ST_SHIFT: w_s_next = r_dir ? S_LEFT : S_RIGHT;
      default:  w_s_next = S_HOLD;
    endcase
    w_d_next = r_d;
    if (w_next == ST_IDLE)
      w_d_next = '0;
    else if (w_accept)
      w_d_next = IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_dir       <= 1'b0;
      r_s         <= S_HOLD;
      r_d         <= '0;
      r_oe        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_s         <= w_s_next;
      r_d         <= w_d_next;
      r_oe        <= (w_next == ST_ENABLE) || (w_next == ST_CAPTURE);
      r_out_valid <= (w_next == ST_OUT);
      r_busy      <= (w_next != ST_IDLE);
      if (w_accept)
        r_dir <= IN_DIR;
      if (r_state == ST_CAPTURE)
        r_out_data <= Q;
    end
  end

  assign S         = r_s;
  assign D         = r_d;
  assign OE        = r_oe;
  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_out_data;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Directed bench for shift_register_sequencer; Q is a stub that only drives while OE is high.
module tb_shift_register_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_DATA;
  logic       IN_DIR;
  logic [2:0] IN_CNT;
  logic [1:0] S;
  logic [3:0] D;
  logic       OE;
  logic [3:0] Q;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] OUT_DATA;
  logic       BUSY;
  logic [3:0] q_stub;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign Q = OE ? q_stub : 4'bzzzz;

  shift_register_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .IN_DIR   (IN_DIR),
    .IN_CNT   (IN_CNT),
    .S        (S),
    .D        (D),
    .OE       (OE),
    .Q        (Q),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA),
    .BUSY     (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and walk it cycle by cycle; hold = cycles OUT_READY stays low in OUT.
  task automatic run_cmd(input logic [3:0] data, input logic dir, input logic [2:0] cnt,
                         input logic [3:0] stub, input int nshift, input int hold);
    @(negedge CLK);
    q_stub    = stub;
    IN_DATA   = data;
    IN_DIR    = dir;
    IN_CNT    = cnt;
    IN_VALID  = 1'b1;
    OUT_READY = (hold == 0);
    chk("idle_in_ready", IN_READY, 1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("load_S", S, 2'b11);
    chk("load_D", D, data);
    chk("load_busy", BUSY, 1);
    chk("load_in_ready", IN_READY, 0);
    for (int i = 0; i < nshift; i++) begin
      @(negedge CLK);
      chk("shift_S", S, dir ? 2'b10 : 2'b01);
      chk("shift_OE", OE, 0);
    end
    @(negedge CLK);
    chk("enable_S", S, 2'b00);
    chk("enable_OE", OE, 1);
    chk("enable_vld", OUT_VALID, 0);
    @(negedge CLK);
    chk("capture_S", S, 2'b00);
    chk("capture_OE", OE, 1);
    chk("capture_vld", OUT_VALID, 0);
    @(negedge CLK);
    chk("out_vld", OUT_VALID, 1);
    chk("out_data", OUT_DATA, stub);
    chk("out_OE", OE, 0);
    chk("out_S", S, 2'b00);
    chk("out_D", D, data);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("bp_vld", OUT_VALID, 1);
      chk("bp_data", OUT_DATA, stub);
      chk("bp_in_ready", IN_READY, 0);
      chk("bp_OE", OE, 0);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("ret_in_ready", IN_READY, 1);
    chk("ret_busy", BUSY, 0);
    chk("ret_vld", OUT_VALID, 0);
    chk("ret_D", D, 0);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_DIR = 1'b0; IN_CNT = '0;
    OUT_READY = 1'b1; q_stub = '0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_S", S, 2'b00);
      chk("rst_OE", OE, 0);
      chk("rst_D", D, 0);
      chk("rst_vld", OUT_VALID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_in_ready", IN_READY, 0);
    end
    RST = 1'b0;
    #1 chk("rel_in_ready", IN_READY, 1);
    chk("rst_out_data", OUT_DATA, 0);

    // Right shift by one
    run_cmd(4'b0101, 1'b0, 3'd1, 4'b0010, 1, 0);
    // Zero count: LOAD straight to ENABLE
    run_cmd(4'b1100, 1'b0, 3'd0, 4'b1100, 0, 0);
    // Count 7 clamps to 4 left shifts
    run_cmd(4'b1011, 1'b1, 3'd7, 4'b1000, 4, 0);
    // Exactly WIDTH, right
    run_cmd(4'b1001, 1'b0, 3'd4, 4'b0001, 4, 0);
    // Backpressure for 10 cycles
    run_cmd(4'b0110, 1'b1, 3'd2, 4'b1010, 2, 10);

    // Reset during the second SHIFT cycle of a count-3 command
    @(negedge CLK);
    q_stub = 4'b0111; IN_DATA = 4'b0011; IN_DIR = 1'b0; IN_CNT = 3'd3; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    chk("mr_load_S", S, 2'b11);
    @(negedge CLK);
    chk("mr_shift1_S", S, 2'b01);
    @(negedge CLK);
    chk("mr_shift2_S", S, 2'b01);
    RST = 1'b1;
    #1 chk("mr_rst_in_ready", IN_READY, 0);
    @(negedge CLK);
    chk("mr_S", S, 2'b00);
    chk("mr_busy", BUSY, 0);
    chk("mr_D", D, 0);
    chk("mr_OE", OE, 0);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("mr_no_vld", OUT_VALID, 0);
      chk("mr_hold_S", S, 2'b00);
    end

    // RST together with IN_VALID: command must not be accepted
    @(negedge CLK);
    RST = 1'b1; IN_VALID = 1'b1; IN_CNT = 3'd1;
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0;
    chk("rv_busy", BUSY, 0);
    chk("rv_S", S, 2'b00);
    @(negedge CLK);
    chk("rv_busy2", BUSY, 0);
    chk("rv_in_ready", IN_READY, 1);

    // Back-to-back after the reset sequence still works
    run_cmd(4'b1110, 1'b1, 3'd3, 4'b0101, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
